// File: rtl/smalldiv_pkg.sv
// smalldiv_pkg: definitions shared by smalldiv and smallmul.
//   state_t  - handshake FSM encodings (IDLE/RUN/DONE)
//   clog2    - ceiling log2, usable in parameter expressions
//   nchunk   - number of CHUNK-bit slices needed to cover a QW-bit quotient
package smalldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int nchunk(input int qw, input int cw);
    return (qw + cw - 1) / cw;
  endfunction

endpackage

// File: rtl/smallmul_chunk_lut.sv
// smallmul_chunk_lut: combinational constant-product ROM.
//   Entry k holds k*DIVIDER_VALUE for every CHUNK_WIDTH-bit slice value k.
// Ports:
//   slice   in   CHUNK_WIDTH                 quotient slice (ROM address)
//   product out  CHUNK_WIDTH+DIVIDER_WIDTH   slice * DIVIDER_VALUE
module smallmul_chunk_lut #(
  parameter int DIVIDER_VALUE = 5,
  parameter int DIVIDER_WIDTH = 3,
  parameter int CHUNK_WIDTH   = 4
) (
  input  logic [CHUNK_WIDTH-1:0]               slice,
  output logic [CHUNK_WIDTH+DIVIDER_WIDTH-1:0] product
);

  localparam int PW      = CHUNK_WIDTH + DIVIDER_WIDTH;
  localparam int ENTRIES = 1 << CHUNK_WIDTH;

  logic [PW-1:0] rom [ENTRIES];

  // (2^CW - 1) * D < 2^CW * 2^DW, so every entry fits in PW bits.
  for (genvar k = 0; k < ENTRIES; k++) begin : g_rom
    assign rom[k] = PW'(k * DIVIDER_VALUE);
  end

  assign product = rom[slice];

endmodule

// File: rtl/smallmul.sv
// smallmul: rebuilds dividend = quotient*DIVIDER_VALUE + remainder, one
// CHUNK_WIDTH-bit quotient slice per cycle via a constant-product LUT.
// Optional feature macro: SMALLMUL_RANGE_CHECK_EN (flags remainder >= DIVIDER_VALUE).
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   in_valid  in   operand pair valid
//   in_ready  out  block can accept an operand pair (IDLE only)
//   quotient  in   QW-bit quotient
//   remainder in   DIVIDER_WIDTH-bit remainder
//   out_valid out  dividend valid (DONE only)
//   out_ready in   consumer accepts dividend
//   dividend  out  reconstructed dividend, stable while out_valid
//   error     out  remainder was out of range (0 unless the feature is built)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready and, once high, stays high with
// stable data until the transfer.
module smallmul
  import smalldiv_pkg::*;
#(
  parameter int DIVIDER_VALUE  = 5,
  parameter int DIVIDER_WIDTH  = 3,
  parameter int DIVIDEND_WIDTH = 18,
  parameter int CHUNK_WIDTH    = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DIVIDEND_WIDTH-DIVIDER_WIDTH-1:0] quotient,
  input  logic [DIVIDER_WIDTH-1:0]            remainder,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DIVIDEND_WIDTH-1:0]           dividend,
  output logic                                error
);

  localparam int QW     = DIVIDEND_WIDTH - DIVIDER_WIDTH;
  localparam int NCHUNK = nchunk(QW, CHUNK_WIDTH);
  localparam int QPAD   = NCHUNK * CHUNK_WIDTH;
  localparam int IW     = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam int PW     = CHUNK_WIDTH + DIVIDER_WIDTH;

  state_t                    state, state_next;
  logic [QPAD-1:0]           q_reg;   // zero-padded so the top slice reads zeros
  logic [DIVIDEND_WIDTH-1:0] acc;
  logic [DIVIDEND_WIDTH-1:0] term;
  logic [DIVIDEND_WIDTH-1:0] acc_sum;
  logic [IW-1:0]             idx;
  logic [CHUNK_WIDTH-1:0]    slice;
  logic [PW-1:0]             prod;
  logic                      accept;
  logic                      last;

  assign slice   = q_reg[idx*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign last    = (idx == IW'(NCHUNK - 1));
  assign accept  = in_valid & in_ready;
  // Carries above DIVIDEND_WIDTH cannot occur for in-range operands and are dropped.
  assign term    = DIVIDEND_WIDTH'(prod) << (idx * CHUNK_WIDTH);
  assign acc_sum = acc + term;

  smallmul_chunk_lut #(
    .DIVIDER_VALUE (DIVIDER_VALUE),
    .DIVIDER_WIDTH (DIVIDER_WIDTH),
    .CHUNK_WIDTH   (CHUNK_WIDTH)
  ) u_lut (
    .slice   (slice),
    .product (prod)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // dividend is a separate register so it only changes when a result lands,
  // leaving the previous result visible through IDLE and RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      acc      <= '0;
      idx      <= '0;
      dividend <= '0;
    end else begin
      if (accept) begin
        q_reg <= QPAD'(quotient);
        acc   <= DIVIDEND_WIDTH'(remainder);
        idx   <= '0;
      end else if (state == RUN) begin
        acc <= acc_sum;
        idx <= last ? '0 : idx + 1'b1;
        if (last) dividend <= acc_sum;
      end
    end
  end

`ifdef SMALLMUL_RANGE_CHECK_EN
  logic error_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       error_q <= 1'b0;
    else if (accept) error_q <= (32'(remainder) >= 32'(DIVIDER_VALUE));
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
